up_down_mode_counter: RTL and testbench

UP_DOWN_MODE_COUNTER -- requirements
Module: up_down_mode_counter

---
 rtl/up_down_pkg.sv | 18 +
 rtl/udc_step.sv | 39 +++
 rtl/up_down_mode_counter.sv | 135 +++++++++++++
 tb/tb_up_down_mode_counter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_down_pkg.sv
// Shared encodings for the up/down mode counter: counting modes and the
// one-shot sequencer states.
package up_down_pkg;

    typedef enum logic [1:0] {
        WRAP     = 2'b00,
        SATURATE = 2'b01,
        ONESHOT  = 2'b10,
        RSVD     = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/udc_step.sv
// Combinational step of the counter: next value for one enabled cycle plus
// the boundary and wrap indications. Boundaries are compared against MAX
// explicitly so a MAX below 2**N-1 never relies on natural rollover.
module udc_step
    import up_down_pkg::*;
#(
    parameter int N   = 4,
    parameter int MAX = (1 << N) - 1
) (
    input  logic [N-1:0] count_i,
    input  logic         up_i,
    input  logic [1:0]   mode_i,
    output logic [N-1:0] next_o,
    output logic         wrap_hit_o,
    output logic         bnd_hit_o
);

    localparam logic [N-1:0] MAX_V = N'(MAX);

    mode_e mode_s;
    logic  wrap_mode;

    assign mode_s = mode_e'(mode_i);

    // Reserved mode counts exactly like WRAP; other modes hold at a boundary.
    always_comb begin
        wrap_mode  = (mode_s == WRAP) || (mode_s == RSVD);
        bnd_hit_o  = up_i ? (count_i == MAX_V) : (count_i == '0);
        wrap_hit_o = bnd_hit_o && wrap_mode;
        if (!bnd_hit_o) begin
            next_o = up_i ? (count_i + N'(1)) : (count_i - N'(1));
        end else if (wrap_mode) begin
            next_o = up_i ? '0 : MAX_V;
        end else begin
            next_o = count_i;
        end
    end

endmodule

// File: rtl/up_down_mode_counter.sv
// Up/down counter with WRAP, SATURATE and ONESHOT modes. Priority per cycle
// is clear > load > en. The one-shot sequencer lives here together with all
// output registers; the arithmetic step comes from udc_step.
//
// state | meaning
// IDLE  | not sequencing, count held in ONESHOT mode
// RUN   | ONESHOT armed by load, counts on each enabled cycle
// DONE  | terminal value reached, count held until load or clear
module up_down_mode_counter
    import up_down_pkg::*;
#(
    parameter int N   = 4,
    parameter int MAX = (1 << N) - 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic         up,
    input  logic [1:0]   mode,
    output logic [N-1:0] count,
    output logic         wrap,
    output logic         sat,
    output logic         done,
    output logic         busy,
    output logic         at_min,
    output logic         at_max
);

    localparam logic [N-1:0] MAX_V = N'(MAX);

    logic [N-1:0] count_q;
    logic         wrap_q;
    logic         sat_q;
    logic         done_q;
    state_e       state_q;

    mode_e        mode_s;
    logic [N-1:0] step_next;
    logic [N-1:0] load_clamped;
    logic [N-1:0] term_val;
    logic         wrap_hit;
    logic         bnd_hit;
    logic         term_hit;

    assign mode_s = mode_e'(mode);

    udc_step #(
        .N   (N),
        .MAX (MAX)
    ) u_step (
        .count_i    (count_q),
        .up_i       (up),
        .mode_i     (mode),
        .next_o     (step_next),
        .wrap_hit_o (wrap_hit),
        .bnd_hit_o  (bnd_hit)
    );

    // Load clamp and one-shot terminal detection for the current direction.
    always_comb begin
        load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
        term_val     = up ? MAX_V : '0;
        term_hit     = (step_next == term_val);
    end

    // Count register, pulse/level flags and one-shot sequencer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            if (clear) begin
                count_q <= '0;
                sat_q   <= 1'b0;
                state_q <= IDLE;
            end else if (load) begin
                count_q <= load_clamped;
                sat_q   <= 1'b0;
                state_q <= (mode_s == ONESHOT) ? RUN : IDLE;
            end else begin
                // Leaving ONESHOT abandons any sequence in progress.
                if (mode_s != ONESHOT) begin
                    state_q <= IDLE;
                end
                case (mode_s)
                    SATURATE: begin
                        if (en) begin
                            count_q <= step_next;
                            sat_q   <= bnd_hit;
                        end else begin
                            // A held level survives only while still pinned
                            // against the boundary in the current direction.
                            sat_q <= sat_q & bnd_hit;
                        end
                    end
                    ONESHOT: begin
                        sat_q <= 1'b0;
                        if ((state_q == RUN) && en) begin
                            count_q <= step_next;
                            // Also covers a load of the terminal value itself.
                            if (term_hit) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        sat_q <= 1'b0;
                        if (en) begin
                            count_q <= step_next;
                            wrap_q  <= wrap_hit;
                        end
                    end
                endcase
            end
        end
    end

    assign count  = count_q;
    assign wrap   = wrap_q;
    assign sat    = sat_q;
    assign done   = done_q;
    assign busy   = (state_q == RUN);
    assign at_min = (count_q == '0);
    assign at_max = (count_q == MAX_V);

endmodule

// File: tb/tb_up_down_mode_counter.sv
// Bench for up_down_mode_counter with N=4, MAX=9: directed scenarios followed
// by a randomized run against a behavioural reference model.
module tb_up_down_mode_counter;

    localparam int N   = 4;
    localparam int MAX = 9;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         clear, load, en, up;
    logic [N-1:0] load_val;
    logic [1:0]   mode;
    logic [N-1:0] count;
    logic         wrap, sat, done, busy, at_min, at_max;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    up_down_mode_counter #(.N(N), .MAX(MAX)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .up       (up),
        .mode     (mode),
        .count    (count),
        .wrap     (wrap),
        .sat      (sat),
        .done     (done),
        .busy     (busy),
        .at_min   (at_min),
        .at_max   (at_max)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic c, input logic l, input logic [N-1:0] lv,
                          input logic e, input logic u, input logic [1:0] md);
        clear = c; load = l; load_val = lv; en = e; up = u; mode = md;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 1, 2'd0);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({count, wrap, sat, done, busy, at_min, at_max} !== {4'd0, 6'b000010}) begin
            errors++;
            $display("FAIL reset_async: got count=%0d w=%b s=%b d=%b b=%b min=%b max=%b, want count=0 flags 0 min=1",
                     count, wrap, sat, done, busy, at_min, at_max);
        end
        tick(); tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if ({count, busy} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: got count=%0d busy=%b, want 0 0", count, busy);
        end
    endtask

    task automatic test_wrap();
        set_in(0, 0, 0, 1, 1, 2'd0);
        for (int i = 1; i <= 11; i++) begin
            tick();
            checks++;
            if ({count, wrap, at_min, at_max} !== {4'(i % 10), (i == 10), (i % 10 == 0), (i % 10 == 9)}) begin
                errors++;
                $display("FAIL wrap_up step %0d: got count=%0d wrap=%b min=%b max=%b, want count=%0d wrap=%b",
                         i, count, wrap, at_min, at_max, i % 10, (i == 10));
            end
        end
        set_in(1, 0, 0, 0, 1, 2'd0); tick();
        set_in(0, 0, 0, 1, 0, 2'd0); tick();
        checks++;
        if ({count, wrap} !== {4'd9, 1'b1}) begin
            errors++;
            $display("FAIL wrap_down: got count=%0d wrap=%b, want 9 1", count, wrap);
        end
        set_in(0, 1, 4'd3, 0, 0, 2'd0); tick();
        set_in(0, 1, 4'd15, 0, 0, 2'd0); tick();
        checks++;
        if ({count, wrap, at_max} !== {4'd9, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL load_clamp: got count=%0d wrap=%b max=%b, want 9 0 1", count, wrap, at_max);
        end
    endtask

    task automatic test_saturate();
        set_in(0, 1, 4'd8, 0, 1, 2'd1); tick();
        set_in(0, 0, 0, 1, 1, 2'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({count, sat} !== {4'd9, (i > 0)}) begin
                errors++;
                $display("FAIL sat_up cycle %0d: got count=%0d sat=%b, want 9 %b", i, count, sat, (i > 0));
            end
        end
        set_in(0, 0, 0, 1, 0, 2'd1); tick();
        checks++;
        if ({count, sat} !== {4'd8, 1'b0}) begin
            errors++;
            $display("FAIL sat_reverse: got count=%0d sat=%b, want 8 0", count, sat);
        end
        set_in(0, 1, 4'd1, 0, 0, 2'd1); tick();
        set_in(0, 0, 0, 1, 0, 2'd1); tick(); tick();
        checks++;
        if ({count, sat} !== {4'd0, 1'b1}) begin
            errors++;
            $display("FAIL sat_low: got count=%0d sat=%b, want 0 1", count, sat);
        end
        set_in(0, 0, 0, 0, 1, 2'd1); tick();
        checks++;
        if ({count, sat} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL sat_dir_away: got count=%0d sat=%b, want 0 0", count, sat);
        end
    endtask

    task automatic test_oneshot();
        set_in(0, 1, 4'd6, 0, 1, 2'd2); tick();
        checks++;
        if ({count, busy, done} !== {4'd6, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL os_load: got count=%0d busy=%b done=%b, want 6 1 0", count, busy, done);
        end
        set_in(0, 0, 0, 1, 1, 2'd2);
        for (int k = 7; k <= 9; k++) begin
            tick();
            checks++;
            if ({count, busy, done} !== {4'(k), (k != 9), (k == 9)}) begin
                errors++;
                $display("FAIL os_run: got count=%0d busy=%b done=%b, want %0d %b %b",
                         count, busy, done, k, (k != 9), (k == 9));
            end
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({count, busy, done} !== {4'd9, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL os_hold: got count=%0d busy=%b done=%b, want 9 0 0", count, busy, done);
            end
        end
        set_in(0, 1, 4'd2, 0, 1, 2'd2); tick();
        checks++;
        if ({count, busy} !== {4'd2, 1'b1}) begin
            errors++;
            $display("FAIL os_restart: got count=%0d busy=%b, want 2 1", count, busy);
        end
        set_in(0, 1, 4'd9, 0, 1, 2'd2); tick();
        set_in(0, 0, 0, 1, 1, 2'd2); tick();
        checks++;
        if ({count, busy, done} !== {4'd9, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL os_load_term: got count=%0d busy=%b done=%b, want 9 0 1", count, busy, done);
        end
        set_in(0, 1, 4'd2, 0, 0, 2'd2); tick();
        set_in(0, 0, 0, 1, 0, 2'd2); tick(); tick();
        checks++;
        if ({count, busy, done} !== {4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL os_down: got count=%0d busy=%b done=%b, want 0 0 1", count, busy, done);
        end
        set_in(0, 1, 4'd3, 0, 1, 2'd2); tick();
        set_in(0, 0, 0, 1, 1, 2'd0); tick();
        checks++;
        if ({count, busy} !== {4'd4, 1'b0}) begin
            errors++;
            $display("FAIL os_mode_leave: got count=%0d busy=%b, want 4 0", count, busy);
        end
    endtask

    task automatic test_priority();
        set_in(0, 1, 4'd5, 0, 1, 2'd2); tick();
        set_in(1, 1, 4'd7, 1, 1, 2'd2); tick();
        checks++;
        if ({count, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL prio_clear: got count=%0d busy=%b done=%b, want 0 0 0", count, busy, done);
        end
        set_in(0, 0, 0, 1, 1, 2'd2); tick();
        checks++;
        if ({count, busy} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL prio_idle_hold: got count=%0d busy=%b, want 0 0", count, busy);
        end
    endtask

    task automatic test_async_reset();
        set_in(0, 1, 4'd2, 0, 1, 2'd2); tick();
        set_in(0, 0, 0, 1, 1, 2'd2); tick(); tick();
        checks++;
        if ({count, busy} !== {4'd4, 1'b1}) begin
            errors++;
            $display("FAIL arst_setup: got count=%0d busy=%b, want 4 1", count, busy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({count, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL arst_immediate: got count=%0d busy=%b done=%b, want 0 0 0", count, busy, done);
        end
        #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({count, busy} !== {4'd0, 1'b0}) begin
                errors++;
                $display("FAIL arst_after: got count=%0d busy=%b, want 0 0", count, busy);
            end
        end
        set_in(0, 1, 4'd5, 1, 1, 2'd2); tick();
        checks++;
        if ({count, busy} !== {4'd5, 1'b1}) begin
            errors++;
            $display("FAIL arst_reload: got count=%0d busy=%b, want 5 1", count, busy);
        end
    endtask

    task automatic test_random();
        int         m_count;
        bit         m_run, m_wrap, m_sat, m_done;
        logic [1:0] cur_mode;
        logic [9:0] exp_v, act_v;
        logic       c, l, e, u;
        logic [N-1:0] lv;
        int         old, tgt, nv;

        set_in(1, 0, 0, 0, 1, 2'd0); tick();
        m_count = 0; m_run = 0; m_wrap = 0; m_sat = 0; m_done = 0;
        cur_mode = 2'd0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 11) == 0) cur_mode = 2'($urandom_range(0, 3));
            c  = ($urandom_range(0, 24) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = 1'($urandom_range(0, 1));
            lv = 4'($urandom_range(0, 15));
            set_in(c, l, lv, e, u, cur_mode);

            old = m_count;
            m_wrap = 0;
            m_done = 0;
            if (c) begin
                m_count = 0; m_run = 0; m_sat = 0;
            end else if (l) begin
                m_count = (int'(lv) > MAX) ? MAX : int'(lv);
                m_run = (cur_mode == 2'd2);
                m_sat = 0;
            end else if (cur_mode == 2'd2) begin
                m_sat = 0;
                if (m_run && e) begin
                    tgt = u ? MAX : 0;
                    if (old != tgt) m_count = u ? old + 1 : old - 1;
                    if (m_count == tgt) begin
                        m_done = 1;
                        m_run = 0;
                    end
                end
            end else if (cur_mode == 2'd1) begin
                m_run = 0;
                if (e) begin
                    nv = u ? old + 1 : old - 1;
                    if (nv > MAX) nv = MAX;
                    if (nv < 0) nv = 0;
                    m_sat = (nv == old);
                    m_count = nv;
                end else begin
                    m_sat = m_sat && (u ? (old == MAX) : (old == 0));
                end
            end else begin
                m_run = 0;
                m_sat = 0;
                if (e) begin
                    m_count = u ? (old + 1) % (MAX + 1) : (old + MAX) % (MAX + 1);
                    m_wrap = u ? (old == MAX) : (old == 0);
                end
            end

            tick();
            exp_v = {4'(m_count), m_wrap, m_sat, m_done, m_run, (m_count == 0), (m_count == MAX)};
            act_v = {count, wrap, sat, done, busy, at_min, at_max};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL random cyc %0d mode=%0d c=%b l=%b lv=%0d e=%b u=%b: got cnt/w/s/d/b/min/max=%0d/%b, want %0d/%b",
                         cyc, cur_mode, c, l, lv, e, u, act_v[9:6], act_v[5:0], exp_v[9:6], exp_v[5:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_saturate();
        test_oneshot();
        test_priority();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
